priority_arbiter_rr: RTL and testbench
======================================

# priority_arbiter_rr

Parametrised, registered successor to the 3-input combinational priority encoder. It takes N_REQ request lines and a per-line enable mask, and selects one eligible requester by fixed priority or round-robin. It presents the winner as a binary index plus a one-hot vector behind a valid/ready handshake. It sits between a bank of request sources and a single shared consumer (bus port, output mux), and holds each grant stable until the consumer accepts it.

## Interface
Parameters:
- N_REQ, 8, number of request lines (2..64).
- IDX_W, $clog2(N_REQ), width of the grant index (derived; do not override).
- RR_MODE, 0, 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- rst_n_i  input  1  asynchronous, active-low reset.
- req_i  input  N_REQ  request vector; bit k = requester k.
- mask_i  input  N_REQ  enable vector; bit k = 1 makes requester k eligible.
- gnt_ready_i  input  1  consumer accepts the current grant.
- gnt_valid_o  output  1  a grant is presented.
- gnt_idx_o  output  IDX_W  binary index of the granted requester; 0 when gnt_valid_o = 0.
- gnt_onehot_o  output  N_REQ  one-hot grant; all zeros when gnt_valid_o = 0.

## Operation
- Eligible vector: elig = req_i & mask_i, sampled combinationally each cycle.
- Fixed mode (RR_MODE = 0): the winner is the highest set index of elig.
- Round-robin mode (RR_MODE = 1): search starts at pointer ptr (IDX_W bits) and goes upward ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1; the first set bit wins. Wrap is at N_REQ-1 → 0 (N_REQ need not be a power of 2).
- Pointer: ptr resets to 0. On each accepted grant, ptr ← (gnt_idx_o + 1) mod N_REQ. The pointer is unused in fixed mode.
- States:
  - IDLE: no grant presented. If elig ≠ 0, latch the winner into gnt_idx_o/gnt_onehot_o, set gnt_valid_o, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: hold gnt_valid_o, gnt_idx_o and gnt_onehot_o stable while gnt_ready_i = 0. Changes to req_i or mask_i do not alter or withdraw a presented grant (sticky grant).
  - Handshake in GRANT (gnt_valid_o & gnt_ready_i):
    - Update ptr.
    - Arbitrate elig in the same cycle, using the updated pointer value (gnt_idx_o + 1) mod N_REQ for round-robin.
    - If elig ≠ 0, load the new winner and stay in GRANT. This allows back-to-back grants with no bubble, and the same requester may win again.
    - Otherwise clear the outputs and go to IDLE.
- gnt_ready_i is ignored in IDLE.
- gnt_onehot_o always equals 1 << gnt_idx_o when valid. Both are derived from the same register, so they never disagree.

## Timing
- Reset (rst_n_i low, asynchronous): state = IDLE, gnt_valid_o = 0, gnt_idx_o = 0, gnt_onehot_o = 0, ptr = 0. Takes effect immediately, including mid-grant; a pending grant is discarded. The first arbitration occurs on the first rising edge after rst_n_i deasserts.
- Latency: eligible request at edge n is sampled and presented as a valid grant after edge n (one cycle from request to valid).
- Throughput: one grant per cycle when gnt_ready_i is held high and elig stays nonzero.
- No combinational path from any input to any output; all outputs are registered.
- Simultaneous events:
  - A requester dropping req_i in the same cycle as its handshake does not affect that handshake.
  - The new arbitration uses the req_i value from that cycle.
- All requests masked (elig = 0) while in IDLE: stay in IDLE with outputs at 0. This matches the "00 when nothing selected" convention.

## Test plan
- Reset/idle: N_REQ = 4; hold rst_n_i low, then release with req_i = 0 → gnt_valid_o = 0, gnt_idx_o = 0, gnt_onehot_o = 0000 for 10 cycles.
- Fixed priority: RR_MODE = 0, req_i = 1011, mask_i = 1111, gnt_ready_i = 1 → grants 3, 3, 3… each cycle. Then set mask_i = 0111 → grants 1, 1…; gnt_onehot_o = 0010.
- Round-robin fairness: RR_MODE = 1, req_i = 1111, mask_i = 1111, gnt_ready_i = 1 from reset → gnt_idx_o sequence 0, 1, 2, 3, 0, 1… with no idle cycles.
- Sticky grant under backpressure: RR_MODE = 1, req_i = 0100, gnt_ready_i = 0 → grant 2 presented. Then drop req_i to 0 and change mask_i for 5 cycles → gnt_idx_o stays 2, gnt_valid_o stays 1. Assert gnt_ready_i for 1 cycle → next cycle gnt_valid_o = 0, ptr = 3.
- Wrap with non-power-of-2: N_REQ = 5, RR_MODE = 1, req_i = 10001, always ready → grants 0, 4, 0, 4…; ptr wraps 4 → 0.
- Reset mid-grant: grant 3 held with gnt_ready_i = 0; pulse rst_n_i low between clock edges → outputs go to 0 immediately, without waiting for a clock edge. After release with req_i = 1111, RR mode grants 0 first (ptr = 0).

Source files
------------

// File: rtl/priority_arbiter_rr.sv
// priority_arbiter_rr: registered fixed-priority / round-robin arbiter with a sticky valid/ready grant.
module priority_arbiter_rr #(
    parameter int N_REQ   = 8,
    parameter int IDX_W   = $clog2(N_REQ),
    parameter int RR_MODE = 0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic             gnt_ready_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic [N_REQ-1:0] gnt_onehot_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, r_ptr;
    logic [IDX_W-1:0] w_idx_nxt, w_ptr_nxt, w_idx_inc, w_start, w_win;
    logic [N_REQ-1:0] w_elig;
    logic             w_hs, w_arb;
    assign w_elig    = req_i & mask_i;
    assign w_hs      = (r_state == GRANT) & gnt_ready_i;
    assign w_arb     = (r_state == IDLE) | w_hs;
    assign w_idx_inc = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
    // on a handshake the search already starts from the pointer being written this cycle
    assign w_start   = w_hs ? w_idx_inc : r_ptr;
    always_comb begin : arbitrate
        int k;
        k     = 0;
        w_win = '0;
        if (RR_MODE != 0) begin
            // scan farthest-first so the bit nearest the start is the last one written
            for (int i = N_REQ - 1; i >= 0; i--) begin
                k = int'(w_start) + i;
                if (k >= N_REQ) k = k - N_REQ;
                if (w_elig[k]) w_win = IDX_W'(k);
            end
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (w_elig[i]) w_win = IDX_W'(i);
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = w_hs ? w_idx_inc : r_ptr;
        if (w_arb) begin
            w_state_nxt = (|w_elig) ? GRANT : IDLE;
            w_idx_nxt   = (|w_elig) ? w_win : '0;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end
    assign gnt_valid_o  = (r_state == GRANT);
    assign gnt_idx_o    = r_idx;
    assign gnt_onehot_o = gnt_valid_o ? (N_REQ'(1) << r_idx) : '0;
endmodule

// File: tb/tb_priority_arbiter_rr.sv
// tb_priority_arbiter_rr: checks fixed (N=4), round-robin (N=4) and round-robin (N=5) instances
// against a cycle-level reference model under directed and random stimulus.
module tb_priority_arbiter_rr;
    logic       clk = 1'b0, rst_n = 1'b0, ready = 1'b0;
    logic [3:0] req4 = '0, mask4 = '0;
    logic [4:0] req5 = '0, mask5 = '0;
    logic       v0, v1, v2;
    logic [1:0] i0, i1;
    logic [2:0] i2;
    logic [3:0] o0, o1;
    logic [4:0] o2;
    int n_err = 0, n_chk = 0;
    int nreq[3] = '{4, 4, 5};
    bit rrm[3]  = '{1'b0, 1'b1, 1'b1};
    bit mv[3];
    int mi[3], mp[3];

    always #5 clk = ~clk;

    priority_arbiter_rr #(.N_REQ(4), .RR_MODE(0)) u_fix4 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req4), .mask_i(mask4), .gnt_ready_i(ready),
        .gnt_valid_o(v0), .gnt_idx_o(i0), .gnt_onehot_o(o0));
    priority_arbiter_rr #(.N_REQ(4), .RR_MODE(1)) u_rr4 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req4), .mask_i(mask4), .gnt_ready_i(ready),
        .gnt_valid_o(v1), .gnt_idx_o(i1), .gnt_onehot_o(o1));
    priority_arbiter_rr #(.N_REQ(5), .RR_MODE(1)) u_rr5 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req5), .mask_i(mask5), .gnt_ready_i(ready),
        .gnt_valid_o(v2), .gnt_idx_o(i2), .gnt_onehot_o(o2));

    function automatic logic [7:0] elig(int d);
        return (d < 2) ? 8'(req4 & mask4) : 8'(req5 & mask5);
    endfunction

    // fixed: largest set index; round-robin: set index at the smallest forward distance from start
    function automatic int pick(logic [7:0] e, int start, int n, bit rr);
        int best = -1, bd = n;
        for (int k = 0; k < n; k++) begin
            if (e[k]) begin
                if (!rr) best = k;
                else if ((k - start + n) % n < bd) begin
                    bd   = (k - start + n) % n;
                    best = k;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            mv[d] = 1'b0;
            mi[d] = 0;
            mp[d] = 0;
        end
    endtask

    task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, d, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] ov, oi, oo;
        for (int d = 0; d < 3; d++) begin
            ov = (d == 0) ? 32'(v0) : (d == 1) ? 32'(v1) : 32'(v2);
            oi = (d == 0) ? 32'(i0) : (d == 1) ? 32'(i1) : 32'(i2);
            oo = (d == 0) ? 32'(o0) : (d == 1) ? 32'(o1) : 32'(o2);
            chk("valid", d, ov, 32'(mv[d]));
            chk("idx", d, oi, 32'(mi[d]));
            chk("onehot", d, oo, mv[d] ? (32'd1 << mi[d]) : 32'd0);
        end
    endtask

    // predict from the inputs in front of the edge, then sample 1 time unit after it
    task automatic tick();
        bit         nv[3];
        int         ni[3], np[3];
        logic [7:0] e;
        for (int d = 0; d < 3; d++) begin
            nv[d] = mv[d];
            ni[d] = mi[d];
            np[d] = mp[d];
            if (!rst_n) begin
                nv[d] = 1'b0;
                ni[d] = 0;
                np[d] = 0;
            end else if (!mv[d] || ready) begin
                if (mv[d]) np[d] = (mi[d] + 1) % nreq[d];
                e = elig(d);
                nv[d] = (e != 0);
                ni[d] = (e != 0) ? pick(e, np[d], nreq[d], rrm[d]) : 0;
            end
        end
        @(posedge clk);
        #1;
        mv = nv;
        mi = ni;
        mp = np;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            chk("idle_valid", 0, 32'(v0), 32'd0);
            chk("idle_onehot", 1, 32'(o1), 32'd0);
        end
        req4 = 4'b1011; mask4 = 4'b1111; ready = 1'b1;
        repeat (4) begin
            tick();
            chk("fixed_hi", 0, 32'(i0), 32'd3);
        end
        mask4 = 4'b0111;
        repeat (3) begin
            tick();
            chk("fixed_mask", 0, 32'(i0), 32'd1);
            chk("fixed_oh", 0, 32'(o0), 32'b0010);
        end
        rst_n = 1'b0;
        #1 model_reset();
        req4 = 4'b1111; mask4 = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_seq", 1, 32'(i1), 32'(i % 4));
            chk("rr_nobubble", 1, 32'(v1), 32'd1);
        end
        req4 = 4'b0100;
        tick();
        chk("sticky_first", 1, 32'(i1), 32'd2);
        ready = 1'b0;
        req4  = 4'b0000;
        repeat (5) begin
            mask4 = 4'($urandom);
            tick();
            chk("sticky_idx", 1, 32'(i1), 32'd2);
            chk("sticky_v", 1, 32'(v1), 32'd1);
        end
        mask4 = 4'b1111; ready = 1'b1;
        tick();
        chk("sticky_drop", 1, 32'(v1), 32'd0);
        ready = 1'b0; req4 = 4'b1111;
        tick();
        chk("ptr_after_2", 1, 32'(i1), 32'd3);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_v", 1, 32'(v1), 32'd0);
        chk("async_oh", 1, 32'(o1), 32'd0);
        chk("async_idx", 1, 32'(i1), 32'd0);
        model_reset();
        check_all();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst", 1, 32'(i1), 32'd0);
        req5 = 5'b10001; mask5 = 5'b11111; ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wrap", 2, 32'(i2), (i % 2) ? 32'd4 : 32'd0);
        end
        repeat (400) begin
            req4  = 4'($urandom);
            mask4 = 4'($urandom | $urandom);
            req5  = 5'($urandom);
            mask5 = 5'($urandom | $urandom);
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_all();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
